// File: rtl/ports_pkg.sv
// Shared definitions for the control-port block: register map, unmapped read
// value, captured-write record and parameter range helpers.
package ports_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_ENABLE = 2'b10;
  localparam logic [1:0] ADDR_CTRL   = 2'b11;

  localparam logic [7:0] RDATA_UNMAPPED = 8'hFF;

  typedef struct packed {
    logic       wrena;
    logic [1:0] addr;
    logic [7:0] wrdata;
  } wr_cap_t;

  function automatic bit in_range(int value, int lo, int hi);
    return (value >= lo) && (value <= hi);
  endfunction

  function automatic bit at_least(int value, int lo);
    return value >= lo;
  endfunction

endpackage

// File: rtl/ports_sync.sv
// Multi-flop synchroniser for one asynchronous bit; the reset value is the
// idle level of the signal so a reset never fabricates an edge.
module ports_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ports_irq_regs.sv
// Control-port register block: synchronised write strobe, sticky W1C interrupt
// pending bits with enable mask, device resets. Optional macro: PORTS_RST_STRETCH_EN.
module ports_irq_regs
  import ports_pkg::*;
#(
  parameter int NUM_IRQ     = 3,
  parameter int NUM_RST     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrstb_n,
  input  logic               wrena,
  input  logic [1:0]         addr,
  input  logic [7:0]         wrdata,
  output logic [7:0]         rddata,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq,
  output logic [NUM_RST-1:0] dev_rst_n
);

  if (!in_range(NUM_IRQ, 1, 8))       begin : g_bad_num_irq  $error("NUM_IRQ out of range"); end
  if (!in_range(NUM_RST, 1, 8))       begin : g_bad_num_rst  $error("NUM_RST out of range"); end
  if (!at_least(SYNC_STAGES, 2))      begin : g_bad_sync     $error("SYNC_STAGES below 2"); end
  if (!at_least(RST_CYCLES, 2))       begin : g_bad_rst_cyc  $error("RST_CYCLES below 2"); end

  // Write strobe path: capture while the synchronised strobe is low, commit on its rise.
  logic    stb_s;
  logic    stb_d;
  wr_cap_t cap;
  logic    commit;
  logic    wr_status, wr_enable, wr_ctrl;

  ports_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb_sync (
    .clk (clk),
    .rst (rst),
    .d   (wrstb_n),
    .q   (stb_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_d <= 1'b1;
      cap   <= '0;
    end else begin
      stb_d <= stb_s;
      if (!stb_s) cap <= '{wrena: wrena, addr: addr, wrdata: wrdata};
    end
  end

  assign commit    = stb_s && !stb_d && cap.wrena;
  assign wr_status = commit && (cap.addr == ADDR_STATUS);
  assign wr_enable = commit && (cap.addr == ADDR_ENABLE);
  assign wr_ctrl   = commit && (cap.addr == ADDR_CTRL);

  // Interrupt sources: per-bit synchroniser then a one-flop rising-edge detector.
  logic [NUM_IRQ-1:0] src_s;
  logic [NUM_IRQ-1:0] src_d;
  logic [NUM_IRQ-1:0] src_rise;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src_sync
    ports_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_src_sync (
      .clk (clk),
      .rst (rst),
      .d   (irq_src[i]),
      .q   (src_s[i])
    );
  end

  assign src_rise = src_s & ~src_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_RST-1:0] ctrl;
  logic [NUM_IRQ-1:0] w1c_mask;

  assign w1c_mask = wr_status ? cap.wrdata[NUM_IRQ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_d   <= '0;
      pending <= '0;
      enable  <= '0;
      ctrl    <= '0;
      irq     <= 1'b0;
    end else begin
      src_d <= src_s;
      // A new edge beats a simultaneous clear of the same bit.
      pending <= (pending & ~w1c_mask) | src_rise;
      if (wr_enable) enable <= cap.wrdata[NUM_IRQ-1:0];
      if (wr_ctrl)   ctrl   <= cap.wrdata[NUM_RST-1:0];
      irq <= |(pending & enable);
    end
  end

  // NOTE: the default assignment up front keeps this combinational block from inferring latches.
  always_comb begin
    rddata = RDATA_UNMAPPED;
    case (addr)
      ADDR_STATUS: begin rddata = '0; rddata[NUM_IRQ-1:0] = pending; end
      ADDR_ENABLE: begin rddata = '0; rddata[NUM_IRQ-1:0] = enable;  end
      ADDR_CTRL:   begin rddata = '0; rddata[NUM_RST-1:0] = ctrl;    end
      default:     rddata = RDATA_UNMAPPED;
    endcase
  end

  // Only the low parameter-width bits of the captured data reach a register.
  logic unused_wrdata;
  assign unused_wrdata = ^cap.wrdata;

`ifdef PORTS_RST_STRETCH_EN
  localparam int              CNT_W    = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES);

  logic [CNT_W-1:0]   rst_cnt [NUM_RST];
  logic [NUM_RST-1:0] rst_n_q;

  // NOTE: the counter array is a handful of flops, not RAM, so it is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RST; i++) rst_cnt[i] <= CNT_LOAD;
      rst_n_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RST; i++) begin
        if (!ctrl[i] || (wr_ctrl && !cap.wrdata[i])) rst_cnt[i] <= CNT_LOAD;
        else if (rst_cnt[i] != '0)                   rst_cnt[i] <= rst_cnt[i] - CNT_W'(1);
        rst_n_q[i] <= ctrl[i] && (rst_cnt[i] == '0);
      end
    end
  end

  assign dev_rst_n = rst_n_q;
`else
  assign dev_rst_n = ctrl;
`endif

endmodule

// File: tb/tb_ports_irq_regs.sv
// Scoreboard bench for ports_irq_regs: expectations are queued as stimulus is
// driven and compared when the DUT outputs are sampled on the falling edge.
module tb_ports_irq_regs;
  import ports_pkg::*;

  localparam int NUM_IRQ     = 3;
  localparam int NUM_RST     = 2;
  localparam int SYNC_STAGES = 2;
  localparam int RST_CYCLES  = 16;
`ifdef PORTS_RST_STRETCH_EN
  localparam int STRETCH = RST_CYCLES + 1;
`else
  localparam int STRETCH = 0;
`endif
  localparam int RSTN_LAT = SYNC_STAGES + 1 + STRETCH;

  logic               clk = 1'b0;
  logic               rst;
  logic               wrstb_n;
  logic               wrena;
  logic [1:0]         addr;
  logic [7:0]         wrdata;
  logic [7:0]         rddata;
  logic [NUM_IRQ-1:0] irq_src;
  logic               irq;
  logic [NUM_RST-1:0] dev_rst_n;

  always #5 clk = ~clk;

  ports_irq_regs #(
    .NUM_IRQ     (NUM_IRQ),
    .NUM_RST     (NUM_RST),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_CYCLES  (RST_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wrstb_n   (wrstb_n),
    .wrena     (wrena),
    .addr      (addr),
    .wrdata    (wrdata),
    .rddata    (rddata),
    .irq_src   (irq_src),
    .irq       (irq),
    .dev_rst_n (dev_rst_n)
  );

  typedef enum {OBS_RD, OBS_IRQ, OBS_RSTN} obs_e;
  typedef struct {
    string      tag;
    obs_e       kind;
    logic [1:0] a;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic push_rd(input string tag, input logic [1:0] a, input logic [7:0] v);
    sb.push_back('{tag: tag, kind: OBS_RD, a: a, val: v});
  endtask

  task automatic push_sig(input string tag, input obs_e k, input logic [7:0] v);
    sb.push_back('{tag: tag, kind: k, a: 2'b00, val: v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        OBS_RD:   begin addr = e.a; #1; check(e.tag, rddata, e.val); end
        OBS_IRQ:  check(e.tag, {7'b0, irq}, e.val);
        default:  check(e.tag, {6'b0, dev_rst_n}, e.val);
      endcase
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a 4-clk strobe and returns on the negedge where it rises; src is applied with the rise.
  task automatic write_rise(input logic wen, input logic [1:0] a, input logic [7:0] d,
                            input logic [NUM_IRQ-1:0] src);
    @(negedge clk);
    wrena = wen; addr = a; wrdata = d; wrstb_n = 1'b0;
    tick(4);
    wrstb_n = 1'b1;
    irq_src = src;
  endtask

  task automatic bus_write(input logic wen, input logic [1:0] a, input logic [7:0] d);
    write_rise(wen, a, d, irq_src);
    tick(SYNC_STAGES + 2);
    wrena = 1'b0;
  endtask

  task automatic measure_rstn(input string tag, input int want);
    int n;
    n = 0;
    while (!dev_rst_n[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(n), 8'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wrstb_n = 1'b1; wrena = 1'b0; addr = 2'b00; wrdata = 8'h00; irq_src = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    push_rd("rst_status", ADDR_STATUS, 8'h00);
    push_rd("rst_enable", ADDR_ENABLE, 8'h00);
    push_rd("rst_ctrl",   ADDR_CTRL,   8'h00);
    push_rd("rst_unmap",  2'b00,       RDATA_UNMAPPED);
    push_sig("rst_irq",  OBS_IRQ,  8'h00);
    push_sig("rst_rstn", OBS_RSTN, 8'h00);
    drain();

    // Plain writes, write-enable qualification and width masking.
    bus_write(1'b1, ADDR_ENABLE, 8'h05);
    push_rd("wr_enable", ADDR_ENABLE, 8'h05);
    drain();
    bus_write(1'b0, ADDR_ENABLE, 8'h02);
    push_rd("wr_noena", ADDR_ENABLE, 8'h05);
    drain();
    bus_write(1'b1, ADDR_ENABLE, 8'hFF);
    push_rd("wr_mask", ADDR_ENABLE, 8'h07);
    drain();
    bus_write(1'b1, 2'b00, 8'h00);
    push_rd("unmap_enable", ADDR_ENABLE, 8'h07);
    push_rd("unmap_rd",     2'b00,       RDATA_UNMAPPED);
    drain();

    // IRQ latency, then W1C with the source still high.
    bus_write(1'b1, ADDR_ENABLE, 8'h01);
    @(negedge clk);
    irq_src[0] = 1'b1;
    tick(SYNC_STAGES + 1);
    push_sig("irq_early", OBS_IRQ, 8'h00);
    push_rd("irq_status", ADDR_STATUS, 8'h01);
    drain();
    tick(1);
    push_sig("irq_lat", OBS_IRQ, 8'h01);
    drain();
    bus_write(1'b1, ADDR_STATUS, 8'h01);
    push_sig("w1c_irq",    OBS_IRQ, 8'h00);
    push_rd("w1c_status", ADDR_STATUS, 8'h00);
    drain();
    tick(5);
    push_sig("level_irq",    OBS_IRQ, 8'h00);
    push_rd("level_status", ADDR_STATUS, 8'h00);
    drain();

    // Masked source still latches pending.
    irq_src[1] = 1'b1;
    tick(SYNC_STAGES + 3);
    push_rd("mask_status", ADDR_STATUS, 8'h02);
    push_sig("mask_irq",  OBS_IRQ,     8'h00);
    drain();

    // W1C coincident with a fresh edge on the same bit: the set wins.
    irq_src[1] = 1'b0;
    tick(SYNC_STAGES + 2);
    write_rise(1'b1, ADDR_STATUS, 8'h02, 3'b011);
    tick(SYNC_STAGES + 2);
    wrena = 1'b0;
    push_rd("coinc_status", ADDR_STATUS, 8'h02);
    drain();
    bus_write(1'b1, ADDR_STATUS, 8'h02);
    push_rd("clear_status", ADDR_STATUS, 8'h00);
    drain();

    // Device reset release, then a mid-count re-assert.
    write_rise(1'b1, ADDR_CTRL, 8'h01, irq_src);
    measure_rstn("rstn_lat", RSTN_LAT);
    wrena = 1'b0;
    tick(2);
    push_rd("ctrl_rd",      ADDR_CTRL, 8'h01);
    push_sig("rstn_val",   OBS_RSTN,  8'h01);
    drain();
    bus_write(1'b1, ADDR_CTRL, 8'h00);
    push_sig("rstn_assert", OBS_RSTN, 8'h00);
    drain();
    bus_write(1'b1, ADDR_CTRL, 8'h01);
    bus_write(1'b1, ADDR_CTRL, 8'h00);
    write_rise(1'b1, ADDR_CTRL, 8'h01, irq_src);
    measure_rstn("rstn_restart", RSTN_LAT);
    wrena = 1'b0;
    bus_write(1'b1, ADDR_CTRL, 8'hFF);
    tick(RST_CYCLES + 4);
    push_rd("ctrl_mask",  ADDR_CTRL, 8'h03);
    push_sig("rstn_both", OBS_RSTN,  8'h03);
    drain();

    // Reset in the middle of a strobe with all interrupts pending.
    bus_write(1'b1, ADDR_ENABLE, 8'h07);
    irq_src = '0;
    tick(SYNC_STAGES + 2);
    irq_src = 3'b111;
    tick(SYNC_STAGES + 3);
    push_rd("pre_status", ADDR_STATUS, 8'h07);
    push_sig("pre_irq",  OBS_IRQ,     8'h01);
    drain();
    @(negedge clk);
    wrena = 1'b1; addr = ADDR_CTRL; wrdata = 8'h02; wrstb_n = 1'b0;
    tick(4);
    rst = 1'b1;
    irq_src = '0;
    tick(2);
    rst = 1'b0;
    wrstb_n = 1'b1;
    tick(SYNC_STAGES + 3);
    wrena = 1'b0;
    push_rd("mid_status", ADDR_STATUS, 8'h00);
    push_rd("mid_enable", ADDR_ENABLE, 8'h00);
    push_rd("mid_ctrl",   ADDR_CTRL,   8'h00);
    push_rd("mid_unmap",  2'b00,       RDATA_UNMAPPED);
    push_sig("mid_irq",  OBS_IRQ,  8'h00);
    push_sig("mid_rstn", OBS_RSTN, 8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
